mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory-access stage directly downstream of the execute stage. It takes the ALU result (effective address), the forwarded rs2 store data and the load/store control. It runs one single-beat transaction on a request/acknowledge data bus, with byte-lane steering and load sign/zero extension. It delivers a registered result to writeback and asserts stall to the upstream pipeline while a bus access is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT cycles without bus_ack before the access is aborted with an error (valid range 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  execute-stage result valid this cycle
alu_result  input  32  effective address, or pass-through result for non-memory ops
rs2_data_in  input  32  store data
mem_read  input  1  load op
mem_write  input  1  store op (mem_read && mem_write together = access error)
funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
rd_addr_in  input  5  destination register
reg_write_in  input  1  writeback enable from decode
stall  output  1  upstream must hold all inputs while 1 (combinational)
bus_req  output  1  registered request, held until ack or timeout
bus_we  output  1  1 = store
bus_addr  output  32  word-aligned address ({addr[31:2],2'b00})
bus_wdata  output  32  lane-replicated store data
bus_be  output  4  byte enables
bus_ack  input  1  one-cycle completion strobe; sampled only in WAIT
bus_rdata  input  32  read data, valid with bus_ack
wb_valid  output  1  one-cycle pulse, result ready
wb_data  output  32  load data or alu_result
wb_rd_addr  output  5  registered rd_addr_in
wb_reg_write  output  1  registered reg_write_in, forced 0 on error or store
wb_err  output  1  misaligned / illegal funct3 / bus timeout (qualified by wb_valid)

Behaviour:
- Reset: state IDLE; bus_req, bus_we, wb_valid, wb_reg_write, wb_err = 0; bus_addr, bus_wdata, wb_data = 0; bus_be = 0; wb_rd_addr = 0; timeout counter = 0. Reset mid-WAIT drops bus_req at that edge; a late ack is ignored.
- FSM states: IDLE and WAIT.
- IDLE, valid_in, no memory op:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write_in.
  - stall=0; one op per cycle.
- IDLE, valid_in, memory op, error conditions (no bus access; next cycle wb_valid=1, wb_err=1, wb_reg_write=0, wb_data=0; stall=0):
  - H/HU with addr[0]=1.
  - W with addr[1:0]!=0.
  - funct3 in {011,110,111}; HU/BU on a store.
  - mem_read && mem_write.
- IDLE, valid_in, legal memory op:
  - stall=1 this cycle.
  - Next edge: go to WAIT; bus_req=1, bus_we=mem_write; latch bus_addr, bus_be, bus_wdata, rd, reg_write; counter=0.
- Store lanes:
  - B: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - H: be=addr[1]?1100:0011, wdata={2{rs2[15:0]}}.
  - W: be=1111, wdata=rs2.
- Load: bus_be per the same rule, bus_wdata=0.
- WAIT: stall=!bus_ack && (counter!=TIMEOUT_CYCLES-1); counter increments each cycle without ack.
- WAIT, bus_ack:
  - Next edge: bus_req=0, state=IDLE.
  - wb_valid=1, wb_err=0.
  - Load: wb_data=extended lane of bus_rdata, selected by latched addr[1:0]. B/H sign-extend; BU/HU zero-extend; W whole word.
  - wb_reg_write = latched reg_write for loads; 0 for stores.
- WAIT timeout: no ack with counter==TIMEOUT_CYCLES-1. Next edge: bus_req=0, IDLE, wb_valid=1, wb_err=1, wb_reg_write=0. Access latency capped at TIMEOUT_CYCLES.
- Back-to-back: stall falls in the ack cycle, so upstream presents the next op. It is evaluated in IDLE on the following cycle, giving a minimum 2-cycle spacing between bus accesses.
- Single-cycle ops give wb_valid exactly 1 cycle after acceptance. Loads with ack in the first WAIT cycle give wb_valid 2 cycles after acceptance.
- Bus contract: bus_addr, bus_be, bus_wdata and bus_we stay stable while bus_req=1.

Test Plan:
- SW alu_result=0x10, rs2=0xDEADBEEF, ack after 2 WAIT cycles -> bus_be=1111, bus_we=1, stall high 3 cycles, wb_valid with wb_reg_write=0, wb_err=0.
- LB addr=0x13, bus_rdata=0x80FF1234 -> bus_be=1000, wb_data=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x12 -> 0x000080FF.
- SH addr=0x22, rs2=0x0000ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x20.
- LW addr=0x06 -> no bus_req ever, wb_valid next cycle with wb_err=1, wb_reg_write=0, stall=0.
- LW with bus_ack held low, TIMEOUT_CYCLES=4 -> bus_req high exactly 4 cycles, then wb_err=1 pulse, state IDLE; a later stray ack produces no wb_valid.
- rst=1 in 2nd WAIT cycle, ack arrives next cycle -> bus_req 0 after reset edge, no wb_valid, all outputs at reset values; a non-memory ADD result of 8 then yields wb_data=8 one cycle later.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: runs one single-beat request/acknowledge bus transaction
// per load/store, steers byte lanes, extends load data and registers the
// writeback result. Non-memory and faulting ops complete in one cycle.
//
// state  | meaning
// IDLE   | accepting ops; non-memory and faulting ops retire next cycle
// WAIT   | bus_req held, waiting for bus_ack or for the timeout count
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_addr_in,
  input  logic        reg_write_in,
  output logic        stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic        wb_err
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_be_q, bus_be_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic        rw_q, rw_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_err_q, wb_err_d;

  logic        is_mem;
  logic        f3_bad;
  logic        misalign;
  logic        op_err;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;

  // Classify the incoming op and build its byte enables and replicated store data
  always_comb begin
    is_mem   = mem_read | mem_write;
    f3_bad   = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111) |
               (mem_write & funct3[2]);
    misalign = ((funct3[1:0] == 2'b01) & alu_result[0]) |
               ((funct3[1:0] == 2'b10) & (alu_result[1:0] != 2'b00));
    op_err   = f3_bad | misalign | (mem_read & mem_write);
    be_new    = 4'b1111;
    wdata_new = rs2_data_in;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << alu_result[1:0];
        wdata_new = {4{rs2_data_in[7:0]}};
      end
      2'b01: begin
        be_new    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{rs2_data_in[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write) wdata_new = '0;
  end

  // Pick the addressed lane of the returned word and extend it
  always_comb begin
    lane_b = 8'(bus_rdata >> {off_q, 3'b000});
    lane_h = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'd0, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'd0, lane_h};
      default: load_data = bus_rdata;
    endcase
  end

  // Next-state, bus and writeback decisions
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_be_d    = bus_be_q;
    off_d       = off_q;
    f3_d        = f3_q;
    rd_d        = rd_q;
    rw_d        = rw_q;
    wb_valid_d  = 1'b0;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_rw_d     = 1'b0;
    wb_err_d    = 1'b0;
    stall       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result;
            wb_rd_d    = rd_addr_in;
            wb_rw_d    = reg_write_in;
          end else if (op_err) begin
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
            wb_data_d  = '0;
            wb_rd_d    = rd_addr_in;
          end else begin
            stall       = 1'b1;
            state_d     = S_WAIT;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_write;
            bus_addr_d  = {alu_result[31:2], 2'b00};
            bus_be_d    = be_new;
            bus_wdata_d = wdata_new;
            off_d       = alu_result[1:0];
            f3_d        = funct3;
            rd_d        = rd_addr_in;
            rw_d        = reg_write_in & mem_read;
          end
        end
      end
      S_WAIT: begin
        if (bus_ack) begin
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = bus_we_q ? 32'd0 : load_data;
          wb_rd_d    = rd_q;
          wb_rw_d    = rw_q;
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered: abort and report, no register write
          state_d    = S_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b1;
          wb_data_d  = '0;
          wb_rd_d    = rd_q;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      rw_q        <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_be_q    <= bus_be_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      rd_q        <= rd_d;
      rw_q        <= rw_d;
      wb_valid_q  <= wb_valid_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_rd_addr   = wb_rd_q;
  assign wb_reg_write = wb_rw_q;
  assign wb_err       = wb_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: randomized ops and bus responses checked every cycle
// against a cycle-scheduled expectation model, plus literal spot checks.
`timescale 1ns/1ps
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk, rst, valid_in, mem_read, mem_write, reg_write_in, bus_ack;
  logic [31:0] alu_result, rs2_data_in, bus_rdata;
  logic [2:0]  funct3;
  logic [4:0]  rd_addr_in;
  logic        stall, bus_req, bus_we, wb_valid, wb_reg_write, wb_err;
  logic [31:0] bus_addr, bus_wdata, wb_data;
  logic [3:0]  bus_be;
  logic [4:0]  wb_rd_addr;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .rs2_data_in(rs2_data_in), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .rd_addr_in(rd_addr_in), .reg_write_in(reg_write_in),
    .stall(stall), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd_addr(wb_rd_addr),
    .wb_reg_write(wb_reg_write), .wb_err(wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    logic        rw;
    logic        err;
  } wb_exp_t;

  wb_exp_t     expq[$];
  int          rq_lo = 1, rq_hi = 0, st_lo = 1, st_hi = 0;
  logic        x_we;
  logic [31:0] x_addr, x_wdata;
  logic [3:0]  x_be;
  bit          chk_en = 0;

  int          total = 0, bad = 0;
  int          stall_cnt = 0, req_cnt = 0, wb_cnt = 0;
  logic [31:0] snap_wb_data, snap_addr, snap_wdata;
  logic        snap_wb_err, snap_wb_rw, snap_we;
  logic [3:0]  snap_be;

  string       lit_nm;
  logic [31:0] lit_got, lit_exp;
  int          lit_seq = 0, lit_done = 0;

  function automatic int m_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Single compare process: literal checks posted by the driver, then per-cycle model checks
  always @(negedge clk) begin : cmp
    wb_exp_t e;
    if (lit_seq != lit_done) begin
      chk(lit_nm, lit_got, lit_exp);
      lit_done = lit_seq;
    end
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(cyc >= st_lo && cyc <= st_hi));
      chk("bus_req", 32'(bus_req), 32'(cyc >= rq_lo && cyc <= rq_hi));
      if (cyc >= rq_lo && cyc <= rq_hi) begin
        chk("bus_we", 32'(bus_we), 32'(x_we));
        chk("bus_addr", bus_addr, x_addr);
        chk("bus_be", 32'(bus_be), 32'(x_be));
        chk("bus_wdata", bus_wdata, x_wdata);
      end
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("wb_rd_addr", 32'(wb_rd_addr), 32'(e.rd));
        chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
        chk("wb_err", 32'(wb_err), 32'(e.err));
        if (e.chk_data) chk("wb_data", wb_data, e.data);
      end else begin
        chk("wb_valid_idle", 32'(wb_valid), 32'd0);
      end
      if (wb_valid) begin
        wb_cnt++;
        snap_wb_data = wb_data;
        snap_wb_err  = wb_err;
        snap_wb_rw   = wb_reg_write;
      end
      if (stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        snap_addr  = bus_addr;
        snap_wdata = bus_wdata;
        snap_be    = bus_be;
        snap_we    = bus_we;
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] g, input logic [31:0] x);
    lit_nm  = nm;
    lit_got = g;
    lit_exp = x;
    lit_seq++;
    @(negedge clk); #1;
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      valid_in     = 1'b0;
      bus_ack      = 1'($urandom_range(0, 1));
      bus_rdata    = $urandom();
      alu_result   = $urandom();
      rs2_data_in  = $urandom();
      mem_read     = 1'($urandom_range(0, 1));
      mem_write    = 1'($urandom_range(0, 1));
      funct3       = 3'($urandom_range(0, 7));
      rd_addr_in   = 5'($urandom_range(0, 31));
      reg_write_in = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
  endtask

  // Present one op at the current cycle, play the slave, return at the cycle after it retires
  task automatic do_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input int dly, input logic [31:0] rdata);
    int n, endc, sz;
    bit legal;
    wb_exp_t e;
    n = cyc;
    valid_in = 1'b1; mem_read = rd_op; mem_write = wr_op; funct3 = f3;
    alu_result = addr; rs2_data_in = rs2; rd_addr_in = rd; reg_write_in = rw;
    bus_ack = 1'b0;
    e.rd = rd;
    e.chk_data = 1'b1;
    sz = m_size(f3);
    legal = (sz != 0) && !(rd_op && wr_op) && !(wr_op && f3[2]);
    if (legal) legal = (int'(addr[1:0]) % sz) == 0;
    if (!rd_op && !wr_op) begin
      e.cyc = n + 1; e.data = addr; e.rw = rw; e.err = 1'b0;
      expq.push_back(e);
      @(posedge clk); #1;
    end else if (!legal) begin
      e.cyc = n + 1; e.data = 32'd0; e.rw = 1'b0; e.err = 1'b1;
      expq.push_back(e);
      @(posedge clk); #1;
    end else begin
      endc    = (dly < TO) ? n + 1 + dly : n + TO;
      x_we    = wr_op;
      x_addr  = addr & 32'hFFFF_FFFC;
      x_be    = 4'(((1 << sz) - 1) << int'(addr[1:0]));
      x_wdata = !wr_op ? 32'd0 :
                (sz == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                (sz == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      rq_lo = n + 1; rq_hi = endc;
      st_lo = n;     st_hi = endc - 1;
      e.cyc      = endc + 1;
      e.err      = (dly >= TO);
      e.rw       = (dly < TO) && rd_op && rw;
      e.chk_data = (dly < TO) && rd_op;
      e.data     = m_load(rdata, addr[1:0], f3);
      expq.push_back(e);
      while (cyc <= endc) begin
        @(posedge clk); #1;
        bus_ack   = (dly < TO) && (cyc == n + 1 + dly);
        bus_rdata = bus_ack ? rdata : $urandom();
      end
    end
    valid_in = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

  initial begin
    int s0, r0, w0, n, k, k2, dly;
    logic [2:0]  f3;
    logic [31:0] a;
    logic        rr, ww;
    logic [31:0] cap [11];

    rst = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
    alu_result = 32'd0; rs2_data_in = 32'd0; rd_addr_in = 5'd0; reg_write_in = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (3) @(posedge clk);
    settle();
    cap[0] = 32'(bus_req); cap[1] = 32'(bus_we); cap[2] = bus_addr; cap[3] = bus_wdata;
    cap[4] = 32'(bus_be); cap[5] = 32'(wb_valid); cap[6] = wb_data; cap[7] = 32'(wb_rd_addr);
    cap[8] = 32'(wb_reg_write); cap[9] = 32'(wb_err); cap[10] = 32'(stall);
    lit("rst_bus_req", cap[0], 0);  lit("rst_bus_we", cap[1], 0);
    lit("rst_bus_addr", cap[2], 0); lit("rst_bus_wdata", cap[3], 0);
    lit("rst_bus_be", cap[4], 0);   lit("rst_wb_valid", cap[5], 0);
    lit("rst_wb_data", cap[6], 0);  lit("rst_wb_rd", cap[7], 0);
    lit("rst_wb_rw", cap[8], 0);    lit("rst_wb_err", cap[9], 0);
    lit("rst_stall", cap[10], 0);
    align();
    rst = 1'b0;
    chk_en = 1'b1;
    align();

    // SW, ack in third WAIT cycle
    s0 = stall_cnt;
    do_op(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3, 1'b1, 2, 32'd0);
    settle();
    lit("sw_stall_cycles", 32'(stall_cnt - s0), 3);
    lit("sw_be", 32'(snap_be), 32'hF);
    lit("sw_we", 32'(snap_we), 1);
    lit("sw_wdata", snap_wdata, 32'hDEADBEEF);
    lit("sw_wb_rw", 32'(snap_wb_rw), 0);
    lit("sw_wb_err", 32'(snap_wb_err), 0);
    align();

    // LB / LBU / LHU lane extraction
    do_op(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 5'd4, 1'b1, 0, 32'h80FF1234);
    settle();
    lit("lb_be", 32'(snap_be), 32'h8);
    lit("lb_data", snap_wb_data, 32'hFFFFFF80);
    align();
    do_op(1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 5'd5, 1'b1, 1, 32'h80FF1234);
    settle();
    lit("lbu_data", snap_wb_data, 32'h00000080);
    align();
    do_op(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 5'd6, 1'b1, 0, 32'h80FF1234);
    settle();
    lit("lhu_data", snap_wb_data, 32'h000080FF);
    lit("lhu_rw", 32'(snap_wb_rw), 1);
    align();

    // SH upper half
    do_op(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD, 5'd1, 1'b0, 1, 32'd0);
    settle();
    lit("sh_be", 32'(snap_be), 32'hC);
    lit("sh_wdata", snap_wdata, 32'hABCDABCD);
    lit("sh_addr", snap_addr, 32'h20);
    align();

    // Misaligned LW: no bus access
    r0 = req_cnt;
    do_op(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 5'd2, 1'b1, 0, 32'd0);
    settle();
    lit("lw_mis_err", 32'(snap_wb_err), 1);
    lit("lw_mis_rw", 32'(snap_wb_rw), 0);
    lit("lw_mis_req", 32'(req_cnt - r0), 0);
    align();

    // Timeout, then stray acks
    r0 = req_cnt;
    do_op(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5'd8, 1'b1, 99, 32'd0);
    settle();
    lit("to_req_cycles", 32'(req_cnt - r0), TO);
    lit("to_err", 32'(snap_wb_err), 1);
    lit("to_rw", 32'(snap_wb_rw), 0);
    align();
    w0 = wb_cnt;
    for (int i = 0; i < 5; i++) begin
      bus_ack = 1'b1;
      bus_rdata = $urandom();
      @(posedge clk); #1;
    end
    bus_ack = 1'b0;
    settle();
    lit("stray_ack_wb", 32'(wb_cnt - w0), 0);
    align();

    // Reset during the second WAIT cycle, ack arriving just after
    w0 = wb_cnt;
    n = cyc;
    valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010;
    alu_result = 32'h40; rd_addr_in = 5'd7; reg_write_in = 1'b1; bus_ack = 1'b0;
    x_we = 1'b0; x_addr = 32'h40; x_be = 4'hF; x_wdata = 32'd0;
    rq_lo = n + 1; rq_hi = n + TO; st_lo = n; st_hi = n + TO - 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    rq_hi = n + 2; st_hi = n + 2;
    @(posedge clk); #1;
    rst = 1'b0; valid_in = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    settle();
    cap[0] = 32'(bus_req); cap[1] = 32'(bus_we); cap[2] = bus_addr; cap[3] = bus_wdata;
    cap[4] = 32'(bus_be); cap[5] = 32'(wb_valid); cap[6] = wb_data; cap[7] = 32'(wb_rd_addr);
    align();
    bus_ack = 1'b0;
    settle();
    lit("rstw_bus_req", cap[0], 0);  lit("rstw_bus_we", cap[1], 0);
    lit("rstw_bus_addr", cap[2], 0); lit("rstw_bus_wdata", cap[3], 0);
    lit("rstw_bus_be", cap[4], 0);   lit("rstw_wb_valid", cap[5], 0);
    lit("rstw_wb_data", cap[6], 0);  lit("rstw_wb_rd", cap[7], 0);
    lit("rstw_no_wb", 32'(wb_cnt - w0), 0);
    align();
    do_op(1'b0, 1'b0, 3'b000, 32'd8, 32'h0, 5'd9, 1'b1, 0, 32'd0);
    settle();
    lit("add_wb_data", snap_wb_data, 32'd8);
    lit("add_wb_rw", 32'(snap_wb_rw), 1);
    align();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle($urandom_range(0, 2));
      k  = $urandom_range(0, 9);
      a  = $urandom();
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      dly = $urandom_range(0, TO + 1);
      if (k < 3) begin
        rr = 1'b0; ww = 1'b0; f3 = 3'($urandom_range(0, 7));
      end else begin
        k2 = $urandom_range(0, 19);
        rr = (k2 == 0) || (k2 < 10);
        ww = (k2 == 0) || (k2 >= 10);
        if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
        else if (ww) f3 = 3'($urandom_range(0, 2));
        else begin
          k2 = $urandom_range(0, 4);
          f3 = (k2 < 3) ? 3'(k2) : 3'(k2 + 1);
        end
      end
      do_op(rr, ww, f3, a, $urandom(), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), dly, $urandom());
    end
    idle(3);
    settle();
    if (expq.size() != 0) begin
      total++; bad++;
      $display("FAIL wb_pending: %0d expected writebacks never seen", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
